// File: rtl/serdes_tx_arbiter_pkg.sv
// Shared constants, state encoding and header formatting for the serializer TX arbiter.
package serdes_pkg;

    localparam logic [7:0]  HDR_MAGIC         = 8'hC3;
    localparam int          HDR_MAGIC_LSB     = 56;
    localparam int          HDR_CH_LSB        = 48;
    localparam logic [63:0] DEFAULT_IDLE_WORD = 64'hA5A5_A5A5_A5A5_A5A5;

    typedef enum logic {
        ARB  = 1'b0,
        DATA = 1'b1
    } arb_state_t;

    // Header: magic byte, channel byte, remaining bits zero.
    function automatic logic [63:0] make_header(input logic [7:0] ch);
        logic [63:0] hdr;
        hdr = '0;
        hdr[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
        hdr[HDR_CH_LSB +: 8]    = ch;
        return hdr;
    endfunction

endpackage

// File: rtl/serdes_tx_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request strictly after last_grant, wrapping around.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   winner,
    output logic              any
);

    logic [CH_W-1:0] idx;

    // Walk from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        winner = last_grant;
        idx    = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = CH_W'((int'(last_grant) + k) % NUM_CH);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/serdes_tx_arbiter.sv
// Round-robin framer feeding one 64-bit serializer: header word per grant, then up to
// BURST_MAX data words from the winning channel, idle fill when nobody requests.
module serdes_tx_arbiter
    import serdes_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CH_W      = 2,
    parameter int          BURST_MAX = 4,
    parameter int          FILL_EN   = 1,
    parameter logic [63:0] IDLE_WORD = DEFAULT_IDLE_WORD
) (
    input  logic                 clk_serial,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    req_valid,
    input  logic [NUM_CH*64-1:0] req_data,
    input  logic [NUM_CH-1:0]    req_last,
    output logic [NUM_CH-1:0]    req_ready,
    output logic [63:0]          ser_data,
    output logic                 ser_valid,
    input  logic                 ser_ready,
    output logic [CH_W-1:0]      grant_ch,
    output logic                 busy
);

    arb_state_t      state_reg, state_next;
    logic [7:0]      count_reg, count_next;
    logic [CH_W-1:0] grant_reg, grant_next;
    logic [63:0]     ser_data_reg, ser_data_next;
    logic            ser_valid_reg, ser_valid_next;

    logic            out_free;
    logic [CH_W-1:0] pick_winner;
    logic            pick_any;
    logic [8:0]      count_inc;
    logic            burst_done;
    logic [63:0]     ch_data [NUM_CH];

    assign out_free   = !ser_valid_reg || ser_ready;
    assign count_inc  = {1'b0, count_reg} + 9'd1;
    assign burst_done = (count_inc == 9'(BURST_MAX));

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_data[gi]   = req_data[64*gi +: 64];
            assign req_ready[gi] = (state_reg == DATA) && (grant_reg == CH_W'(gi)) && out_free;
        end
    endgenerate

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (grant_reg),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    always_ff @(posedge clk_serial or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ARB;
            count_reg     <= '0;
            grant_reg     <= CH_W'(NUM_CH - 1);
            ser_data_reg  <= '0;
            ser_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            grant_reg     <= grant_next;
            ser_data_reg  <= ser_data_next;
            ser_valid_reg <= ser_valid_next;
        end
    end

    // A loaded word, fill or not, is only ever replaced once the serializer has taken it.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        grant_next     = grant_reg;
        ser_data_next  = ser_data_reg;
        ser_valid_next = ser_valid_reg;
        case (state_reg)
            ARB: begin
                if (out_free) begin
                    if (pick_any) begin
                        grant_next     = pick_winner;
                        ser_data_next  = make_header(8'(pick_winner));
                        ser_valid_next = 1'b1;
                        count_next     = '0;
                        state_next     = DATA;
                    end else if (FILL_EN != 0) begin
                        ser_data_next  = IDLE_WORD;
                        ser_valid_next = 1'b1;
                    end else begin
                        ser_valid_next = 1'b0;
                    end
                end
            end
            DATA: begin
                if (out_free) begin
                    if (req_valid[grant_reg]) begin
                        ser_data_next  = ch_data[grant_reg];
                        ser_valid_next = 1'b1;
                        count_next     = count_inc[7:0];
                        if (req_last[grant_reg] || burst_done) begin
                            state_next = ARB;
                        end
                    end else begin
                        // Source stalled mid-burst: go quiet rather than fill.
                        ser_valid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    assign ser_data  = ser_data_reg;
    assign ser_valid = ser_valid_reg;
    assign grant_ch  = grant_reg;
    assign busy      = (state_reg == DATA);

endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// Scoreboard bench for serdes_tx_arbiter: per-channel source models, expected words queued
// at stimulus time and compared as the serializer handshake completes.
module tb_serdes_tx_arbiter;

    localparam logic [63:0] IDLE = 64'hA5A5_A5A5_A5A5_A5A5;

    logic         clk_serial = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_last, req_ready;
    logic [255:0] req_data;
    logic [63:0]  ser_data;
    logic         ser_valid, ser_ready;
    logic [1:0]   grant_ch;
    logic         busy;

    logic [3:0]   nf_req_valid, nf_req_last, nf_req_ready;
    logic [255:0] nf_req_data;
    logic [63:0]  nf_ser_data;
    logic         nf_ser_valid, nf_ser_ready;
    logic [1:0]   nf_grant_ch;
    logic         nf_busy;

    int unsigned src_sent [4] = '{default: 0};
    int unsigned src_target [4];
    logic        src_en [4];
    logic        src_has_last [4];

    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          fill_seen = 0;

    always #5 clk_serial = ~clk_serial;

    serdes_tx_arbiter dut (
        .clk_serial (clk_serial),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .grant_ch   (grant_ch),
        .busy       (busy)
    );

    serdes_tx_arbiter #(.FILL_EN(0)) dut_nf (
        .clk_serial (clk_serial),
        .rst_n      (rst_n),
        .req_valid  (nf_req_valid),
        .req_data   (nf_req_data),
        .req_last   (nf_req_last),
        .req_ready  (nf_req_ready),
        .ser_data   (nf_ser_data),
        .ser_valid  (nf_ser_valid),
        .ser_ready  (nf_ser_ready),
        .grant_ch   (nf_grant_ch),
        .busy       (nf_busy)
    );

    function automatic logic [63:0] word_of(input int c, input int unsigned i);
        return {8'hD0 + 8'(c), 8'h5A, 16'h0000, i[31:0]};
    endfunction

    function automatic logic [63:0] hdr_of(input int c);
        return {8'hC3, 8'(c), 48'h0};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_size(input int n, input int budget);
        int k;
        k = 0;
        while (exp_q.size() > n && k < budget) begin
            @(negedge clk_serial);
            #1;
            k++;
        end
        if (exp_q.size() > n) check_eq("wait_timeout", 64'(exp_q.size()), 64'(n));
    endtask

    task automatic push_packet(input int c, input int unsigned base, input int n);
        exp_q.push_back(hdr_of(c));
        for (int i = 0; i < n; i++) exp_q.push_back(word_of(c, base + i));
    endtask

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int c = 0; c < 4; c++) begin
            req_valid[c]         = src_en[c] && (src_sent[c] < src_target[c]);
            req_last[c]          = src_has_last[c] && (src_sent[c] + 1 == src_target[c]);
            req_data[64*c +: 64] = word_of(c, src_sent[c]);
        end
    end

    always @(posedge clk_serial) begin
        for (int c = 0; c < 4; c++) begin
            if (req_valid[c] && req_ready[c]) src_sent[c] <= src_sent[c] + 1;
        end
    end

    // ser_ready only changes just after a rising edge, so valid&&ready here means a transfer.
    always @(negedge clk_serial) begin
        logic [63:0] exp;
        if (rst_n && ser_valid && ser_ready) begin
            if (ser_data == IDLE) begin
                fill_seen++;
                $display("[%0t] fill  %h", $time, ser_data);
            end else begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE;
                $display("[%0t] word  %h grant=%0d expected %h", $time, ser_data, grant_ch, exp);
                check_eq("ser_word", ser_data, exp);
                if (exp[63:56] == 8'hC3) check_eq("grant_ch", 64'(grant_ch), 64'(exp[55:48]));
            end
        end
    end

    initial begin
        int unsigned b0, b1, b2, b3;
        rst_n        = 1'b0;
        ser_ready    = 1'b1;
        nf_req_valid = '0;
        nf_req_last  = '0;
        nf_req_data  = '0;
        nf_ser_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            src_target[c]   = 0;
            src_en[c]       = 1'b0;
            src_has_last[c] = 1'b0;
        end

        #12;
        check_eq("rst_ser_valid", 64'(ser_valid), 64'd0);
        check_eq("rst_ser_data", ser_data, 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_grant_ch", 64'(grant_ch), 64'd3);
        check_eq("rst_busy", 64'(busy), 64'd0);
        @(negedge clk_serial);
        rst_n = 1'b1;

        // Idle fill on the main instance, silence on the FILL_EN=0 instance.
        repeat (2) @(negedge clk_serial);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_serial);
            #1;
            check_eq("fill_valid", 64'(ser_valid), 64'd1);
            check_eq("fill_data", ser_data, IDLE);
            check_eq("nofill_valid", 64'(nf_ser_valid), 64'd0);
        end

        // ch2 sends a 3-word packet.
        @(posedge clk_serial);
        #1;
        b2 = src_sent[2];
        push_packet(2, b2, 3);
        src_has_last[2] = 1'b1;
        src_target[2]   = b2 + 3;
        src_en[2]       = 1'b1;
        wait_size(0, 50);
        check_eq("single_grant", 64'(grant_ch), 64'd2);
        check_eq("single_busy", 64'(busy), 64'd0);

        // ch0 burst with 10 cycles of serializer backpressure after its first data word.
        b0 = src_sent[0];
        push_packet(0, b0, 4);
        src_has_last[0] = 1'b1;
        src_target[0]   = b0 + 4;
        src_en[0]       = 1'b1;
        wait_size(3, 50);
        @(posedge clk_serial);
        #1;
        ser_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_serial);
            check_eq("bp_data", ser_data, word_of(0, b0 + 1));
            check_eq("bp_valid", 64'(ser_valid), 64'd1);
            check_eq("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk_serial);
        #1;
        ser_ready = 1'b1;
        wait_size(0, 50);
        check_eq("bp_sent", 64'(src_sent[0]), 64'(b0 + 4));

        // ch1 stalls after its first data word, then resumes.
        b1 = src_sent[1];
        push_packet(1, b1, 3);
        src_has_last[1] = 1'b1;
        src_target[1]   = b1 + 3;
        src_en[1]       = 1'b1;
        wait_size(2, 50);
        src_en[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_serial);
            #1;
            check_eq("stall_valid", 64'(ser_valid), 64'd0);
            check_eq("stall_busy", 64'(busy), 64'd1);
        end
        src_en[1] = 1'b1;
        wait_size(0, 50);
        check_eq("stall_done_busy", 64'(busy), 64'd0);

        // Reset pulse after two data words of a 4-word ch1 packet.
        b1 = src_sent[1];
        exp_q.push_back(hdr_of(1));
        exp_q.push_back(word_of(1, b1));
        exp_q.push_back(word_of(1, b1 + 1));
        src_target[1] = b1 + 4;
        src_en[1]     = 1'b1;
        wait_size(0, 50);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ser_valid", 64'(ser_valid), 64'd0);
        check_eq("arst_ser_data", ser_data, 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_grant_ch", 64'(grant_ch), 64'd3);
        check_eq("arst_req_ready", 64'(req_ready), 64'd0);
        check_eq("arst_sent", 64'(src_sent[1]), 64'(b1 + 2));
        src_en[1]     = 1'b0;
        src_target[1] = src_sent[1];
        @(negedge clk_serial);
        rst_n = 1'b1;

        // All four channels valid with no last: grants 0,1,2,3,0, four words each.
        @(posedge clk_serial);
        #1;
        b0 = src_sent[0];
        b1 = src_sent[1];
        b2 = src_sent[2];
        b3 = src_sent[3];
        push_packet(0, b0, 4);
        push_packet(1, b1, 4);
        push_packet(2, b2, 4);
        push_packet(3, b3, 4);
        push_packet(0, b0 + 4, 4);
        for (int c = 0; c < 4; c++) begin
            src_has_last[c] = 1'b0;
            src_en[c]       = 1'b1;
        end
        src_target[0] = b0 + 8;
        src_target[1] = b1 + 4;
        src_target[2] = b2 + 4;
        src_target[3] = b3 + 4;
        wait_size(0, 200);
        check_eq("rr_grant_end", 64'(grant_ch), 64'd0);
        check_eq("rr_busy_end", 64'(busy), 64'd0);
        check_eq("rr_sent_ch3", 64'(src_sent[3]), 64'(b3 + 4));

        @(negedge clk_serial);
        #1;
        check_eq("fill_resume", ser_data, IDLE);
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serdes_tx_arbiter.md
Name: serdes_tx_arbiter

Overview:
Round-robin scheduler that shares one serializer_64to1_serdes between NUM_CH independent 64-bit word sources. Each grant is framed as one header word, then up to BURST_MAX data words from the winner. When no source is requesting, the block optionally emits idle fill words to keep the link toggling. It sits directly upstream of the serializer's data_in/valid_in/ready_out handshake, in the same clk_serial domain.

Parameters:
NUM_CH, 4, number of requesters (2..16)
CH_W, 2, width of the channel index; equals clog2(NUM_CH)
BURST_MAX, 4, maximum data words per grant (1..255)
FILL_EN, 1, 1 = emit IDLE_WORD when idle; 0 = ser_valid stays low when idle
IDLE_WORD, 64'hA5A5_A5A5_A5A5_A5A5, idle fill pattern

Ports:
clk_serial  in  1  serial-domain clock
rst_n  in  1  reset
req_valid  in  NUM_CH  per-channel word valid
req_data  in  NUM_CH*64  per-channel word; channel i occupies [64*i+63:64*i]
req_last  in  NUM_CH  marks the final word of a channel's packet
req_ready  out  NUM_CH  per-channel accept
ser_data  out  64  to serializer data_in
ser_valid  out  1  to serializer valid_in
ser_ready  in  1  from serializer ready_out
grant_ch  out  CH_W  channel currently or most recently granted
busy  out  1  high while in the DATA state

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_serial.
- Reset values: ser_valid=0, ser_data=0, req_ready=0, grant_ch=NUM_CH-1, busy=0, state=ARB, burst count=0.
- Output register: ser_data/ser_valid are registered. It is "free" when !ser_valid || ser_ready. While ser_valid && !ser_ready, ser_data is held stable and nothing new loads.
- States: ARB and DATA.
- ARB with any req_valid set and the output register free:
  - Pick the winner: first set bit searching from grant_ch+1 upward, with wrap-around.
  - Next edge: grant_ch=winner, ser_data=header, ser_valid=1, state=DATA, count=0.
  - Header word: [63:56]=8'hC3, [55:48]=winner zero-extended to 8 bits, [47:0]=0.
  - No data word is accepted in the ARB cycle.
- ARB with no req_valid and the output register free:
  - FILL_EN=1: load IDLE_WORD, ser_valid=1.
  - FILL_EN=0: ser_valid=0.
- ARB with a fill word pending and a request arriving: the request waits until the register is free. A fill word already loaded is never retracted.
- DATA state:
  - req_ready[g] = (state==DATA) && (g==grant_ch) && output free. Combinational; all other req_ready bits are 0.
  - On req_valid[g] && req_ready[g]: ser_data=req_data[g], ser_valid=1, count++.
  - If req_last[g] was accepted or count reaches BURST_MAX: return to ARB on the same edge.
- Burst end with no last: a burst hitting BURST_MAX without req_last ends the grant anyway. The channel re-arbitrates and its next grant gets a new header.
- Requester stalls in DATA (req_valid[g] low):
  - Stay in DATA. Once the current word is consumed, ser_valid drops to 0.
  - No fill words are inserted mid-burst.
- Fairness: the pointer advances only via grant_ch. A channel holding valid continuously gets at most BURST_MAX words before each other requesting channel is served.
- Latency: request visible in ARB -> header on ser_data 1 cycle later -> first data word accepted the following cycle, provided ser_ready=1.
- busy = (state==DATA).
- Reset asserted mid-burst: immediate return to reset values. The partial packet is dropped. The source must resend.

Decomposition:
- Package serdes_pkg holds:
  - HDR_MAGIC = 8'hC3
  - header field offsets
  - state enum {ARB, DATA}
  - default IDLE_WORD
- One sub-module is natural: rr_pick. It is a combinational rotate-priority encoder with inputs (req vector, last grant) and outputs (winner, any). Instantiated once.

Test Plan:
- Single channel, reset released, ch2 sends 3 words with last on the 3rd, ser_ready=1:
  - Header 64'hC302_0000_0000_0000, then the 3 words on consecutive cycles.
  - grant_ch=2, then return to ARB.
- All 4 channels continuously valid, no last, BURST_MAX=4:
  - Grant order 0,1,2,3,0.
  - Each grant is 1 header + 4 data words.
  - No channel is served twice while another is requesting.
- No requests, FILL_EN=1:
  - ser_data=64'hA5A5_A5A5_A5A5_A5A5 with ser_valid=1 every cycle.
  - With FILL_EN=0, ser_valid stays 0.
- Backpressure, ser_ready low for 10 cycles mid-burst:
  - ser_data/ser_valid stay stable.
  - req_ready[g]=0 throughout.
  - No word is lost or duplicated after ser_ready returns.
- Requester ch1 drops valid after 1 of 3 words:
  - ser_valid falls, busy stays 1, no fill words.
  - Resume completes the packet under the same header.
- rst_n pulsed low mid-burst (after 2 words):
  - Outputs take reset values asynchronously.
  - The next grant starts from ch0 with a fresh header.
